// File: rtl/rfaludm_pkg.sv
// Shared types and encodings for the multicycle register-file / ALU / data-memory datapath.
package rfaludm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FIN
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [3:0] ALUC_AND   = 4'b0000;
    localparam logic [3:0] ALUC_OR    = 4'b0001;
    localparam logic [3:0] ALUC_ADD   = 4'b0010;
    localparam logic [3:0] ALUC_SUB   = 4'b0110;
    localparam logic [3:0] ALUC_PASSB = 4'b0111;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

endpackage

// File: rtl/rfaludm_alu.sv
// ALU-control decode plus ALU; purely combinational, zero latency, no handshake.
// illegal flags an undecodable ALUOp/opcode pair; result is then 0.
module rfaludm_alu
    import rfaludm_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        aluop,
    input  logic [10:0]       opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              illegal
);

    logic [3:0] ctrl;

    always_comb begin
        ctrl    = ALUC_ADD;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD:   ctrl = ALUC_ADD;
            ALUOP_PASSB: ctrl = ALUC_PASSB;
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_ADD: ctrl = ALUC_ADD;
                    OPC_SUB: ctrl = ALUC_SUB;
                    OPC_AND: ctrl = ALUC_AND;
                    OPC_ORR: ctrl = ALUC_OR;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        result = '0;
        if (!illegal) begin
            case (ctrl)
                ALUC_AND:   result = a & b;
                ALUC_OR:    result = a | b;
                ALUC_ADD:   result = a + b;
                ALUC_SUB:   result = a - b;
                ALUC_PASSB: result = b;
                default:    result = '0;
            endcase
        end
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rfaludm_multicycle.sv
// Multicycle LEGv8-style datapath: one command per start/done, 3-5 cycles from the start edge.
// start is ignored while busy; ExtWrite preloads a register only in IDLE.
module rfaludm_multicycle
    import rfaludm_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int NREG      = 32,
    parameter int REG_AW    = $clog2(NREG),
    parameter int MEM_DEPTH = 128,
    parameter int MEM_AW    = $clog2(MEM_DEPTH),
    parameter int IMM_W     = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [REG_AW-1:0] Read1,
    input  logic [REG_AW-1:0] Read2,
    input  logic [REG_AW-1:0] WriteReg,
    input  logic [1:0]        ALUOp,
    input  logic [10:0]       OpCodefield,
    input  logic              AluSrc,
    input  logic [IMM_W-1:0]  SEin,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              ExtWrite,
    input  logic [REG_AW-1:0] ExtWriteReg,
    input  logic [DATA_W-1:0] ExtWriteData,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Result,
    output logic              Zero,
    output logic              err
);

    localparam logic [REG_AW-1:0] XZR       = REG_AW'(NREG - 1);
    localparam logic [DATA_W-1:0] MEM_BYTES = DATA_W'(8 * MEM_DEPTH);

    state_t state, state_nxt;

    logic [REG_AW-1:0] read1_q, read2_q, writereg_q;
    logic [1:0]        aluop_q;
    logic [10:0]       opcode_q;
    logic              alusrc_q;
    logic [IMM_W-1:0]  sein_q;
    logic              memread_q, memwrite_q, memtoreg_q, regwrite_q;

    logic [DATA_W-1:0] a_q, b_q, sd_q, result_q;
    logic              zero_q, err_q;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];

    logic [DATA_W-1:0] rdata1, rdata2, sext_imm, alu_res;
    logic              alu_zero, alu_illegal, cmd_err, addr_err;
    logic [MEM_AW-1:0] mem_idx;

    assign rdata1   = (read1_q == XZR) ? '0 : regs[read1_q];
    assign rdata2   = (read2_q == XZR) ? '0 : regs[read2_q];
    assign sext_imm = {{(DATA_W-IMM_W){sein_q[IMM_W-1]}}, sein_q};

    rfaludm_alu #(.DATA_W(DATA_W)) u_alu (
        .aluop   (aluop_q),
        .opcode  (opcode_q),
        .a       (a_q),
        .b       (b_q),
        .result  (alu_res),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    assign cmd_err = alu_illegal | (memread_q & memwrite_q);
    // result_q still holds ALUOut while in MEM, so it doubles as the byte address
    assign addr_err = (result_q[2:0] != 3'b000) || (result_q >= MEM_BYTES);
    assign mem_idx  = result_q[MEM_AW+2:3];

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_DEC;
            S_DEC:  state_nxt = S_EXEC;
            S_EXEC: begin
                if (cmd_err)                    state_nxt = S_FIN;
                else if (memread_q | memwrite_q) state_nxt = S_MEM;
                else if (regwrite_q)            state_nxt = S_WB;
                else                            state_nxt = S_FIN;
            end
            S_MEM:  state_nxt = (!addr_err && memread_q && regwrite_q) ? S_WB : S_FIN;
            S_WB:   state_nxt = S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FIN);
    assign Result = result_q;
    assign Zero   = zero_q;
    assign err    = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            read1_q    <= '0;
            read2_q    <= '0;
            writereg_q <= '0;
            aluop_q    <= '0;
            opcode_q   <= '0;
            alusrc_q   <= 1'b0;
            sein_q     <= '0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sd_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        read1_q    <= Read1;
                        read2_q    <= Read2;
                        writereg_q <= WriteReg;
                        aluop_q    <= ALUOp;
                        opcode_q   <= OpCodefield;
                        alusrc_q   <= AluSrc;
                        sein_q     <= SEin;
                        memread_q  <= MemRead;
                        memwrite_q <= MemWrite;
                        memtoreg_q <= MemtoReg;
                        regwrite_q <= RegWrite;
                        err_q      <= 1'b0;
                    end
                end
                S_DEC: begin
                    a_q  <= rdata1;
                    b_q  <= alusrc_q ? sext_imm : rdata2;
                    sd_q <= rdata2;
                end
                S_EXEC: begin
                    result_q <= alu_res;
                    zero_q   <= alu_zero;
                    if (cmd_err) err_q <= 1'b1;
                end
                S_MEM: begin
                    if (addr_err)                       err_q    <= 1'b1;
                    else if (memread_q && memtoreg_q)   result_q <= mem[mem_idx];
                end
                default: ;
            endcase
        end
    end

    // ExtWrite and WB are mutually exclusive because WB is never IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (state == S_IDLE && ExtWrite && ExtWriteReg != XZR) begin
            regs[ExtWriteReg] <= ExtWriteData;
        end else if (state == S_WB && writereg_q != XZR) begin
            regs[writereg_q] <= result_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state == S_MEM && memwrite_q && !addr_err)
            mem[mem_idx] <= sd_q;
    end

endmodule

// File: doc/rfaludm_multicycle.md
Name: rfaludm_multicycle

Overview:
Parametrised multicycle successor to the single-cycle register-file/ALU/data-memory datapath.
- Contents: LEGv8-style register file, ALU with ALU-control decode, sign-extender and doubleword data memory, sequenced by an FSM.
- Operation: executes one command per start/done handshake; supports ADD/SUB/AND/ORR, LDUR/STUR and CBZ-style zero test.
- Debug: adds a debug preload port and error reporting that the single-cycle block lacks.

Parameters:
DATA_W, 64, datapath/register width
NREG, 32, register count; register NREG-1 is XZR
REG_AW, $clog2(NREG), register index width
MEM_DEPTH, 128, data memory depth in DATA_W words
MEM_AW, $clog2(MEM_DEPTH), word index width
IMM_W, 9, SEin width

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  command request, sampled only in IDLE
Read1  in  REG_AW  source register A
Read2  in  REG_AW  source register B / store data
WriteReg  in  REG_AW  destination register
ALUOp  in  2  00 add, 01 pass-B, 10 R-type decode
OpCodefield  in  11  R-type opcode
AluSrc  in  1  0 = B from register, 1 = sign-extended SEin
SEin  in  IMM_W  immediate
MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  command controls
ExtWrite  in  1  debug register preload strobe
ExtWriteReg  in  REG_AW  preload index
ExtWriteData  in  DATA_W  preload data
busy  out  1  command in flight
done  out  1  one-cycle completion pulse
Result  out  DATA_W  ALU result, or load data when MemtoReg
Zero  out  1  ALU result == 0
err  out  1  command faulted; valid with done

Behaviour:
- Reset values: state IDLE; busy, done, err, Zero = 0; Result = 0; all registers = 0. Data memory is not cleared.
- Reset mid-command: abort immediately; no register or memory write from the aborted command commits.
- Command fields are latched at the accepting edge. Inputs may change afterwards.
- start is ignored while busy.
- FSM states and transitions:
  - IDLE -> DEC on start.
  - DEC: latch A = R[Read1]; B = AluSrc ? sext(SEin) : R[Read2]; store data = R[Read2]. Go to EXEC.
  - EXEC: latch ALUOut and Zero. Then go to MEM if MemRead|MemWrite, else WB if RegWrite, else FIN.
  - MEM: address check and access. Then WB if MemRead&RegWrite, else FIN.
  - WB: write the register. Go to FIN.
  - FIN: done = 1. Go to IDLE.
- busy is 1 in every state except IDLE.
- Latency, counted as edges after the start edge to the done cycle: R-type 4, LDUR 5, STUR 4, CBZ (ALUOp 01, no writes) 3.
- ALU control:
  - ALUOp 00 -> add; 01 -> pass B.
  - ALUOp 10 with OpCodefield: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR.
  - Any other opcode, ALUOp 11, or MemRead&MemWrite together: err = 1, no writes, go EXEC -> FIN.
- Arithmetic: add/sub modulo 2^DATA_W, carry discarded. sext replicates SEin[IMM_W-1].
- Memory:
  - Byte address = ALUOut; word index = ALUOut[MEM_AW+2:3].
  - If ALUOut[2:0] != 0 or ALUOut >= 8*MEM_DEPTH: err = 1, access and writeback suppressed.
  - Store writes the store data. Load latches mem[index] into Result when MemtoReg.
- XZR: index NREG-1 reads 0; writes to it are dropped silently, without err.
- Register read during WB of the same register is not a hazard: commands are serial.
- ExtWrite is honoured only in IDLE and ignored when busy. An ExtWrite coincident with an accepted start commits first, and that command sees the new value.
- Result and Zero hold until the next command's EXEC. err clears when the next command is accepted.

Decomposition:
- Shared package rfaludm_pkg:
  - state enum;
  - ALUOp codes;
  - 4-bit ALU control codes (0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 pass-B);
  - R-type opcode constants.
- One natural sub-module, rfaludm_alu: combinational ALU-control decode plus ALU, outputs result, zero and illegal flag.
- Register file and memory stay inline as arrays.

Test Plan:
- Reset, then ExtWrite X1 = 5 and X2 = 3; R-type ADD (OpCodefield 10001011000), RegWrite, WriteReg = X3 -> done 4 cycles after start, Result = 8, Zero = 0, X3 = 8.
- SUB X4 = X1 - X1 -> Result = 0, Zero = 1. Then STUR X2 at [X31 + 40] followed by LDUR X5 from [X31 + 40] with MemtoReg -> done at 4 and 5 cycles; X5 = 3.
- Store 64'haaaaaaaaaaaaaaaa at address 80, load address 80 -> Result = 64'haaaaaaaaaaaaaaaa. Then load address 44 (misaligned) -> err = 1 with done, destination register unchanged.
- Address 8*MEM_DEPTH, illegal opcode 11111111111, and MemRead&MemWrite together -> err = 1, memory and registers unchanged.
- Write to XZR and read it back -> 0. SEin = 9'h1FF with AluSrc = 1, ADD from X31 -> Result = all ones.
- Reset asserted in MEM of a store -> memory word unchanged, busy = 0 next cycle. A start pulse while busy is ignored, so exactly one done is produced.
